// File: rtl/coherence_bus_arbiter_if.sv
// Shared snooping-coherence bus bundle between the arbiter, the cpu ports and main memory.
interface coherence_bus_arbiter_if #(
  parameter int unsigned NUM_CPUS = 3
);
  localparam int unsigned BUS_W = 13;

  logic [NUM_CPUS-1:0]       req;
  logic [BUS_W*NUM_CPUS-1:0] cpu_bus_out;
  logic [NUM_CPUS-1:0]       grant;
  logic [BUS_W-1:0]          bus_in;
  logic [2:0]                mem_addr;
  logic [3:0]                mem_wdata;
  logic                      mem_we;
  logic [3:0]                mem_rdata;
  logic                      busy;
  logic                      timeout;

  // Arbiter side owns grant, the broadcast bus and the memory port.
  modport master (
    input  req, cpu_bus_out, mem_rdata,
    output grant, bus_in, mem_addr, mem_wdata, mem_we, busy, timeout
  );

  modport slave (
    output req, cpu_bus_out, mem_rdata,
    input  grant, bus_in, mem_addr, mem_wdata, mem_we, busy, timeout
  );
endinterface

// File: rtl/coherence_bus_arbiter.sv
// Round-robin owner of the shared coherence bus: grant, capture, broadcast,
// snoop, then answer the miss from a write-back or from main memory.
module coherence_bus_arbiter #(
  parameter int unsigned NUM_CPUS        = 3,
  parameter int unsigned CAPTURE_TIMEOUT = 15
) (
  input logic                     clock,
  input logic                     reset,
  coherence_bus_arbiter_if.master bus
);
  localparam int unsigned BUS_W   = 13;
  localparam int unsigned MSG_W   = 6;
  localparam int unsigned TIMER_W = 4;
  localparam int unsigned IDX_W   = (NUM_CPUS > 1) ? $clog2(NUM_CPUS) : 1;

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    BROADCAST,
    SNOOP,
    RESPOND
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_CPUS-1:0]  grant_q, grant_d;
  logic [BUS_W-1:0]     bus_in_q, bus_in_d;
  logic [2:0]           mem_addr_q, mem_addr_d;
  logic [3:0]           mem_wdata_q, mem_wdata_d;
  logic                 mem_we_q, mem_we_d;
  logic                 busy_q, busy_d;
  logic                 timeout_q, timeout_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [MSG_W-1:0]     msg_q, msg_d;

  logic                 rr_found;
  logic [IDX_W-1:0]     rr_idx;
  logic                 win_valid;
  logic [MSG_W-1:0]     win_msg;
  logic                 win_req;
  logic                 snp_found;
  logic [2:0]           snp_addr;
  logic [3:0]           snp_data;
  logic [3:0]           ack_data;

  // Round-robin pick: first request strictly after the pointer, then wrap.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int unsigned i = 0; i < NUM_CPUS; i++) begin
      if (!rr_found && (i > 32'(ptr_q)) && bus.req[i]) begin
        rr_found = 1'b1;
        rr_idx   = IDX_W'(i);
      end
    end
    for (int unsigned i = 0; i < NUM_CPUS; i++) begin
      if (!rr_found && (i <= 32'(ptr_q)) && bus.req[i]) begin
        rr_found = 1'b1;
        rr_idx   = IDX_W'(i);
      end
    end
  end

  // Granted cpu's port view plus the lowest-index snoop responder among the others.
  always_comb begin
    win_valid = 1'b0;
    win_msg   = '0;
    win_req   = 1'b0;
    snp_found = 1'b0;
    snp_addr  = '0;
    snp_data  = '0;
    for (int unsigned i = 0; i < NUM_CPUS; i++) begin
      if (i == 32'(ptr_q)) begin
        win_valid = bus.cpu_bus_out[BUS_W*i + 10];
        win_msg   = bus.cpu_bus_out[BUS_W*i + 4 +: MSG_W];
        win_req   = bus.req[i];
      end else if (!snp_found &&
                   (bus.cpu_bus_out[BUS_W*i + 12] || bus.cpu_bus_out[BUS_W*i + 11])) begin
        snp_found = 1'b1;
        snp_addr  = bus.cpu_bus_out[BUS_W*i + 4 +: 3];
        snp_data  = bus.cpu_bus_out[BUS_W*i +: 4];
      end
    end
  end

  // Invalidates carry no data; a write-back only supplies data for the requested line.
  always_comb begin
    if (msg_q[3]) begin
      ack_data = 4'h0;
    end else if (snp_found && (snp_addr == msg_q[2:0])) begin
      ack_data = snp_data;
    end else begin
      ack_data = bus.mem_rdata;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    bus_in_d    = '0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    busy_d      = busy_q;
    timeout_d   = 1'b0;
    ptr_d       = ptr_q;
    timer_d     = timer_q;
    msg_d       = msg_q;
    unique case (state_q)
      IDLE: begin
        grant_d = '0;
        busy_d  = 1'b0;
        if (rr_found) begin
          grant_d = NUM_CPUS'(1) << rr_idx;
          ptr_d   = rr_idx;
          timer_d = '0;
          busy_d  = 1'b1;
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        if (win_valid) begin
          msg_d    = win_msg;
          bus_in_d = {3'b000, win_msg, 4'b0000};
          state_d  = BROADCAST;
        end else if (!win_req) begin
          grant_d = '0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (timer_q == TIMER_W'(CAPTURE_TIMEOUT)) begin
          grant_d   = '0;
          busy_d    = 1'b0;
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      BROADCAST: begin
        // Point memory at the line early so the read data is ready during SNOOP.
        mem_addr_d = msg_q[2:0];
        state_d    = SNOOP;
      end
      SNOOP: begin
        if (snp_found) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = snp_addr;
          mem_wdata_d = snp_data;
        end else begin
          mem_addr_d  = msg_q[2:0];
        end
        bus_in_d = {3'b001, msg_q, ack_data};
        state_d  = RESPOND;
      end
      RESPOND: begin
        grant_d = '0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        grant_d = '0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      bus_in_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      busy_q      <= 1'b0;
      timeout_q   <= 1'b0;
      ptr_q       <= IDX_W'(NUM_CPUS - 1);
      timer_q     <= '0;
      msg_q       <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      bus_in_q    <= bus_in_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      busy_q      <= busy_d;
      timeout_q   <= timeout_d;
      ptr_q       <= ptr_d;
      timer_q     <= timer_d;
      msg_q       <= msg_d;
    end
  end

  assign bus.grant     = grant_q;
  assign bus.bus_in    = bus_in_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.busy      = busy_q;
  assign bus.timeout   = timeout_q;
endmodule

// File: tb/tb_coherence_bus_arbiter.sv
// Directed bench for coherence_bus_arbiter: read miss, write-back, round-robin,
// invalidate, capture timeout and reset during SNOOP.
module tb_coherence_bus_arbiter;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   errors  = 0;

  coherence_bus_arbiter_if #(.NUM_CPUS(3)) bus ();

  coherence_bus_arbiter #(.NUM_CPUS(3), .CAPTURE_TIMEOUT(15)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".grant"},   16'(bus.grant),   16'h0);
    chk({tag, ".bus_in"},  16'(bus.bus_in),  16'h0);
    chk({tag, ".mem_we"},  16'(bus.mem_we),  16'h0);
    chk({tag, ".busy"},    16'(bus.busy),    16'h0);
    chk({tag, ".timeout"}, 16'(bus.timeout), 16'h0);
  endtask

  logic [12:0] rr_msg   [4];
  logic [12:0] rr_ack   [4];
  logic [2:0]  rr_grant [4];

  initial begin
    bus.req         = 3'b000;
    bus.cpu_bus_out = '0;
    bus.mem_rdata   = 4'h0;
    rr_grant[0] = 3'b001; rr_grant[1] = 3'b010; rr_grant[2] = 3'b100; rr_grant[3] = 3'b001;
    rr_ack[0] = 13'h613;  rr_ack[1] = 13'h523;  rr_ack[2] = 13'h633;  rr_ack[3] = 13'h613;

    tick(); tick();
    chk_idle("reset");
    chk("reset.mem_addr",  16'(bus.mem_addr),  16'h0);
    chk("reset.mem_wdata", 16'(bus.mem_wdata), 16'h0);
    reset = 1'b0;

    // Read miss from cpu1, served by memory
    bus.req = 3'b010;
    bus.cpu_bus_out[25:13] = 13'h620;
    bus.mem_rdata = 4'hA;
    tick();
    chk("rd.grant", 16'(bus.grant), 16'h2);
    chk("rd.busy",  16'(bus.busy),  16'h1);
    tick();
    chk("rd.bcast", 16'(bus.bus_in), 16'h220);
    tick();
    chk("rd.snoop_bus", 16'(bus.bus_in), 16'h0);
    chk("rd.snoop_we",  16'(bus.mem_we), 16'h0);
    tick();
    chk("rd.ack",    16'(bus.bus_in), 16'h62A);
    chk("rd.ack_we", 16'(bus.mem_we), 16'h0);
    bus.req = 3'b000;
    bus.cpu_bus_out = '0;
    tick();
    chk_idle("rd.done");

    // cpu0 read miss answered by cpu2 write-back
    bus.req = 3'b001;
    bus.cpu_bus_out[12:0]  = 13'h630;
    bus.cpu_bus_out[38:26] = 13'h1035;
    bus.mem_rdata = 4'hF;
    tick();
    chk("wb.grant", 16'(bus.grant), 16'h1);
    tick();
    chk("wb.bcast", 16'(bus.bus_in), 16'h230);
    tick();
    chk("wb.snoop_we", 16'(bus.mem_we), 16'h0);
    tick();
    chk("wb.ack",   16'(bus.bus_in),    16'h635);
    chk("wb.we",    16'(bus.mem_we),    16'h1);
    chk("wb.addr",  16'(bus.mem_addr),  16'h3);
    chk("wb.wdata", 16'(bus.mem_wdata), 16'h5);
    bus.req = 3'b000;
    bus.cpu_bus_out = '0;
    tick();
    chk_idle("wb.done");

    // Round-robin with all cpus requesting from a fresh reset
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.req = 3'b111;
    bus.cpu_bus_out[12:0]  = 13'h610;
    bus.cpu_bus_out[25:13] = 13'h520;
    bus.cpu_bus_out[38:26] = 13'h630;
    bus.mem_rdata = 4'h3;
    for (int t = 0; t < 4; t++) begin
      tick();
      chk($sformatf("rr%0d.grant", t), 16'(bus.grant), 16'(rr_grant[t]));
      tick(); tick(); tick();
      chk($sformatf("rr%0d.ack", t), 16'(bus.bus_in), 16'(rr_ack[t]));
      tick();
      chk($sformatf("rr%0d.gap", t), 16'(bus.grant), 16'h0);
    end
    bus.req = 3'b000;
    bus.cpu_bus_out = '0;
    tick();
    chk_idle("rr.done");

    // Invalidate from cpu1: no data, no memory write
    bus.req = 3'b010;
    bus.cpu_bus_out[25:13] = 13'h4C0;
    bus.mem_rdata = 4'h7;
    tick();
    chk("inv.grant", 16'(bus.grant), 16'h2);
    tick();
    chk("inv.bcast", 16'(bus.bus_in), 16'h0C0);
    tick(); tick();
    chk("inv.ack", 16'(bus.bus_in), 16'h4C0);
    chk("inv.we",  16'(bus.mem_we), 16'h0);
    bus.req = 3'b000;
    bus.cpu_bus_out = '0;
    tick();
    chk_idle("inv.done");

    // Capture timeout on cpu2, cpu0 pending behind it
    bus.req = 3'b100;
    tick();
    chk("to.grant", 16'(bus.grant), 16'h4);
    bus.req = 3'b101;
    for (int t = 0; t < 15; t++) tick();
    chk("to.hold_grant",   16'(bus.grant),   16'h4);
    chk("to.hold_timeout", 16'(bus.timeout), 16'h0);
    tick();
    chk("to.pulse", 16'(bus.timeout), 16'h1);
    chk("to.grant0", 16'(bus.grant),  16'h0);
    chk("to.busy",  16'(bus.busy),    16'h0);
    tick();
    chk("to.next_grant", 16'(bus.grant),   16'h1);
    chk("to.pulse_end",  16'(bus.timeout), 16'h0);
    bus.req = 3'b000;
    tick();
    chk_idle("to.abort");

    // Reset asserted while a write-back is being snooped
    bus.req = 3'b010;
    bus.cpu_bus_out[25:13] = 13'h620;
    bus.cpu_bus_out[38:26] = 13'h1035;
    tick();
    chk("rst.grant", 16'(bus.grant), 16'h2);
    tick(); tick();
    chk("rst.snoop_busy", 16'(bus.busy), 16'h1);
    reset = 1'b1;
    tick();
    chk_idle("rst.mid");
    chk("rst.mem_addr", 16'(bus.mem_addr), 16'h0);
    reset = 1'b0;
    bus.req = 3'b111;
    bus.cpu_bus_out[12:0] = 13'h610;
    tick();
    chk("rst.first_grant", 16'(bus.grant), 16'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
